// File: rtl/mac_drain_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_pkg : shared widths, FIFO entry type and requantiser for the MAC drain
// Rev 1.0
// ----------------------------------------------------------------------------
package mac_pkg;

    localparam int ACC_W  = 39;
    localparam int DATA_W = 16;

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(32'sd32767);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-32'sd32768);

    typedef struct packed {
        logic                     sat;
        logic signed [DATA_W-1:0] data;
    } fifo_entry_t;

    // Round-half-up: adding half an LSB before an arithmetic shift rounds ties
    // towards +inf for both signs.
    function automatic fifo_entry_t requant(input logic signed [ACC_W-1:0] acc,
                                            input int unsigned             shift);
        logic signed [ACC_W:0] w_ext;
        logic signed [ACC_W:0] w_half;
        logic signed [ACC_W:0] w_rnd;
        logic signed [ACC_W:0] w_shr;
        fifo_entry_t           r;
        w_ext  = {acc[ACC_W-1], acc};
        w_half = '0;
        if (shift > 0) begin
            w_half = (ACC_W+1)'(1) << (shift - 1);
        end
        w_rnd  = w_ext + w_half;
        w_shr  = w_rnd >>> shift;
        r.sat  = 1'b0;
        r.data = w_shr[DATA_W-1:0];
        if (w_shr > SAT_HI) begin
            r.sat  = 1'b1;
            r.data = SAT_HI[DATA_W-1:0];
        end else if (w_shr < SAT_LO) begin
            r.sat  = 1'b1;
            r.data = SAT_LO[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_drain_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_drain_if : ALU-side beat/clear signals and result valid/ready port
// Rev 1.0
// ----------------------------------------------------------------------------
interface mac_drain_if;
    import mac_pkg::*;

    logic                     valid_in;
    logic signed [ACC_W-1:0]  y;
    logic                     ready_in;
    logic                     acc_clr;
    logic                     valid_out;
    logic signed [DATA_W-1:0] data_out;
    logic                     sat_out;
    logic                     ready_out;

    modport slave (
        input  valid_in, y, ready_out,
        output ready_in, acc_clr, valid_out, data_out, sat_out
    );

    modport master (
        output valid_in, y, ready_out,
        input  ready_in, acc_clr, valid_out, data_out, sat_out
    );

endinterface
`default_nettype wire

// File: rtl/mac_drain_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drain_fifo : show-ahead synchronous FIFO, output holds last value when empty
// Rev 1.0
// ----------------------------------------------------------------------------
module drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  wire logic                     clk,
    input  wire logic                     R_n,
    input  wire logic                     wr_en_i,
    input  wire logic [WIDTH-1:0]         wr_data_i,
    input  wire logic                     rd_en_i,
    output logic      [WIDTH-1:0]         rd_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             w_push;
    logic             w_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign w_push    = wr_en_i && !full_o;
    assign w_pop     = rd_en_i && !empty_o;
    // Head is visible combinationally; once drained, the last popped entry stays.
    assign rd_data_o = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_drain : counts MAC beats, captures/requantises each vector sum, queues it
// Rev 1.0
// ----------------------------------------------------------------------------
module mac_drain
    import mac_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int SHIFT   = 0,
    parameter int DEPTH   = 4
) (
    input wire logic   clk,
    input wire logic   R_n,
    mac_drain_if.slave bus
);

    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W  = $bits(fifo_entry_t);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cap_pend_q, cap_pend_d;
    logic              acc_clr_q, acc_clr_d;
    logic              w_ready;
    logic              w_beat;
    logic              w_last;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FCNT_W-1:0] w_count;
    fifo_entry_t       w_req;
    fifo_entry_t       w_head;

    assign w_ready = !acc_clr_q && !cap_pend_q && !w_full;
    assign w_beat  = bus.valid_in && w_ready;
    assign w_last  = (cnt_q == CNT_W'(VEC_LEN - 1));
    assign w_req   = requant(bus.y, SHIFT);
    assign w_pop   = bus.ready_out && (w_count != '0);

    // The completing beat schedules both the capture and the ALU clear; the
    // capture edge itself is the one on which the ALU samples R=1.
    always_comb begin
        cnt_d      = cnt_q;
        cap_pend_d = 1'b0;
        acc_clr_d  = 1'b0;
        if (w_beat) begin
            if (w_last) begin
                cnt_d      = '0;
                cap_pend_d = 1'b1;
                acc_clr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt_q      <= '0;
            cap_pend_q <= 1'b0;
            acc_clr_q  <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            cap_pend_q <= cap_pend_d;
            acc_clr_q  <= acc_clr_d;
        end
    end

    drain_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .R_n       (R_n),
        .wr_en_i   (cap_pend_q),
        .wr_data_i (w_req),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_count)
    );

    assign bus.ready_in  = w_ready;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.valid_out = !w_empty;
    assign bus.data_out  = w_head.data;
    assign bus.sat_out   = w_head.sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_drain : table vectors over three SHIFT settings plus VEC_LEN=1 instance
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mac_drain;
    import mac_pkg::*;

    typedef struct {
        int a0; int b0; int a1; int b1; int a2; int b2; int a3; int b3;
        int e0; int e1; int e2;
        int s;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    R_n;
    logic                    feed, feed3, rdy_o;
    logic signed [15:0]      fa, fb;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] acc0 = '0;
    logic signed [ACC_W-1:0] acc3 = '0;
    int                      n_chk = 0;
    int                      n_pass = 0;
    logic [16:0]             sbq [4][$];
    vec_t                    vt [8];
    logic [3:0]              mv, mr, ms;
    logic [15:0]             md [4];

    always #5 clk = ~clk;

    mac_drain_if bus0 ();
    mac_drain_if bus1 ();
    mac_drain_if bus2 ();
    mac_drain_if bus3 ();

    mac_drain #(.VEC_LEN(4), .SHIFT(0), .DEPTH(4)) u_dut0 (.clk(clk), .R_n(R_n), .bus(bus0));
    mac_drain #(.VEC_LEN(4), .SHIFT(1), .DEPTH(4)) u_dut1 (.clk(clk), .R_n(R_n), .bus(bus1));
    mac_drain #(.VEC_LEN(4), .SHIFT(2), .DEPTH(4)) u_dut2 (.clk(clk), .R_n(R_n), .bus(bus2));
    mac_drain #(.VEC_LEN(1), .SHIFT(0), .DEPTH(4)) u_dut3 (.clk(clk), .R_n(R_n), .bus(bus3));

    assign w_prod         = fa * fb;
    assign bus0.valid_in  = feed && bus0.ready_in;
    assign bus1.valid_in  = feed && bus1.ready_in;
    assign bus2.valid_in  = feed && bus2.ready_in;
    assign bus3.valid_in  = feed3 && bus3.ready_in;
    assign bus0.y         = acc0;
    assign bus1.y         = acc0;
    assign bus2.y         = acc0;
    assign bus3.y         = acc3;
    assign bus0.ready_out = rdy_o;
    assign bus1.ready_out = rdy_o;
    assign bus2.ready_out = rdy_o;
    assign bus3.ready_out = 1'b1;

    // ALU models: accumulate gated beats, clear when acc_clr is sampled high
    always @(posedge clk) begin
        if (bus0.acc_clr)       acc0 <= '0;
        else if (bus0.valid_in) acc0 <= acc0 + ACC_W'(w_prod);
        if (bus3.acc_clr)       acc3 <= '0;
        else if (bus3.valid_in) acc3 <= acc3 + ACC_W'(w_prod);
    end

    assign mv    = {bus3.valid_out, bus2.valid_out, bus1.valid_out, bus0.valid_out};
    assign mr    = {bus3.ready_out, bus2.ready_out, bus1.ready_out, bus0.ready_out};
    assign ms    = {bus3.sat_out, bus2.sat_out, bus1.sat_out, bus0.sat_out};
    assign md[0] = bus0.data_out;
    assign md[1] = bus1.data_out;
    assign md[2] = bus2.data_out;
    assign md[3] = bus3.data_out;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    // Scoreboard: every popped result is compared with the oldest expectation
    always @(negedge clk) begin
        if (R_n) begin
            for (int k = 0; k < 4; k++) begin
                if (mv[k] && mr[k]) begin
                    if (sbq[k].size() == 0) begin
                        n_chk++;
                        $display("FAIL dut%0d_out: got unexpected %0d, required none", k, $signed(md[k]));
                    end else begin
                        logic [16:0] e;
                        e = sbq[k].pop_front();
                        chk($sformatf("dut%0d_data", k), int'($signed(md[k])), int'($signed(e[15:0])));
                        chk($sformatf("dut%0d_sat", k), int'(ms[k]), int'(e[16]));
                    end
                end
            end
        end
    end

    task automatic beat(input int a, input int b);
        int cyc = 0;
        fa   = 16'(a);
        fb   = 16'(b);
        feed = 1'b1;
        while (!bus0.ready_in && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 50) begin
            n_chk++;
            $display("FAIL beat_wait: got ready_in=0 for %0d cycles, required 1", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic vec(input vec_t v);
        beat(v.a0, v.b0);
        beat(v.a1, v.b1);
        beat(v.a2, v.b2);
        beat(v.a3, v.b3);
        feed = 1'b0;
        sbq[0].push_back({v.s[0], 16'(v.e0)});
        sbq[1].push_back({v.s[1], 16'(v.e1)});
        sbq[2].push_back({v.s[2], 16'(v.e2)});
    endtask

    task automatic drain();
        int cyc = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        R_n = 1'b0; feed = 1'b0; feed3 = 1'b0; rdy_o = 1'b1; fa = '0; fb = '0;
        vt[0] = '{2, 3, 5, 4, 1, 1, 16, 3, 75, 38, 19, 0};
        vt[1] = '{200, 200, 0, 0, 0, 0, 0, 0, 32767, 20000, 10000, 1};
        vt[2] = '{-200, 200, 0, 0, 0, 0, 0, 0, -32768, -20000, -10000, 1};
        vt[3] = '{-128, 256, 0, 0, 0, 0, 0, 0, -32768, -16384, -8192, 0};
        vt[4] = '{-5, 1, 0, 0, 0, 0, 0, 0, -5, -2, -1, 0};
        vt[5] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 7};
        vt[6] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 2, 1, 0};
        vt[7] = '{3, 1, 0, 0, 0, 0, 0, 0, 3, 2, 1, 0};

        repeat (2) @(negedge clk);
        chk("rst_acc_clr", bus0.acc_clr, 1);
        chk("rst_ready_in", bus0.ready_in, 0);
        chk("rst_valid_out", bus0.valid_out, 0);
        chk("rst_data_out", bus0.data_out, 0);
        chk("rst_sat_out", bus0.sat_out, 0);
        @(posedge clk); #1 R_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_acc_clr", bus0.acc_clr, 0);
        chk("rel_ready_in", bus0.ready_in, 1);

        for (int i = 0; i < 8; i++) begin
            vec(vt[i]);
            if (i == 0) begin
                @(negedge clk);
                chk("cap_acc_clr", bus0.acc_clr, 1);
                chk("cap_ready_in", bus0.ready_in, 0);
                chk("cap_valid_out", bus0.valid_out, 0);
                @(negedge clk);
                chk("post_acc_clr", bus0.acc_clr, 0);
                chk("lat_valid_out", bus0.valid_out, 1);
            end
        end
        drain();

        // VEC_LEN=1: every accepted beat forces a capture bubble
        @(posedge clk); #1;
        fa = 16'sd3; fb = 16'sd7; feed3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("v1_ready_%0d", i), bus3.ready_in, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("v1_clr_%0d", i), bus3.acc_clr, (i % 2 == 0) ? 0 : 1);
            if (bus3.ready_in) sbq[3].push_back({1'b0, 16'd21});
        end
        @(posedge clk); #1 feed3 = 1'b0;
        drain();

        // Back-pressure: fill the FIFO, stray beats must be ignored
        rdy_o = 1'b0;
        for (int k = 1; k <= 4; k++) vec('{k, 1, 0, 0, 0, 0, 0, 0, k, (k + 1) / 2, (k + 2) / 4, 0});
        repeat (2) @(posedge clk);
        #1 fa = 16'sd9; fb = 16'sd1; feed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("full_ready_%0d", i), bus0.ready_in, 0);
        end
        @(posedge clk); #1 feed = 1'b0; rdy_o = 1'b1;
        @(posedge clk); #1 rdy_o = 1'b0;
        @(negedge clk);
        chk("pop_ready_in", bus0.ready_in, 1);
        vec('{5, 1, 0, 0, 0, 0, 0, 0, 5, 3, 1, 0});
        rdy_o = 1'b1;
        drain();
        chk("hold_valid_out", bus0.valid_out, 0);
        chk("hold_data_out", bus0.data_out, 5);
        chk("hold_data_out2", bus2.data_out, 1);

        // Reset mid-vector with one entry queued
        rdy_o = 1'b0;
        vec(vt[6]);
        repeat (2) @(negedge clk);
        chk("q_valid_out", bus0.valid_out, 1);
        chk("q_data_out", bus0.data_out, 4);
        beat(1, 1);
        beat(1, 1);
        feed = 1'b0;
        #2 R_n = 1'b0;
        #1;
        chk("arst_acc_clr", bus0.acc_clr, 1);
        chk("arst_valid_out", bus0.valid_out, 0);
        chk("arst_data_out", bus0.data_out, 0);
        chk("arst_ready_in", bus0.ready_in, 0);
        for (int k = 0; k < 4; k++) sbq[k].delete();
        @(posedge clk); #1 R_n = 1'b1;
        @(posedge clk); #1;
        chk("rerel_acc_clr", bus0.acc_clr, 0);
        rdy_o = 1'b1;
        vec(vt[6]);
        drain();

        for (int k = 0; k < 4; k++) chk($sformatf("sb%0d_left", k), sbq[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
